// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if: scan control in (i_RUN, i_STEP, i_LAST) and select/qualifier out (i_A, i_B, i_C, i_VALID, i_TICK, i_WRAP)
interface scan_sequencer_if;
  logic       i_RUN;
  logic       i_STEP;
  logic [2:0] i_LAST;
  logic       i_A;
  logic       i_B;
  logic       i_C;
  logic       i_VALID;
  logic       i_TICK;
  logic       i_WRAP;
  modport master (output i_RUN, i_STEP, i_LAST, input i_A, i_B, i_C, i_VALID, i_TICK, i_WRAP);
  modport slave  (input i_RUN, i_STEP, i_LAST, output i_A, i_B, i_C, i_VALID, i_TICK, i_WRAP);
endinterface

// File: rtl/scan_sequencer.sv
// scan_sequencer: timed 3-bit scan index for a 3-to-8 decoder; ports i_clk, i_rst, bus (scan_sequencer_if.slave: i_RUN/i_STEP/i_LAST in, i_A/i_B/i_C/i_VALID/i_TICK/i_WRAP out); define SCAN_SEQ_BLANK_EN for a BLANK_CYCLES gap between dwells
module scan_sequencer #(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  scan_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam int DW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  if (PRESCALE < 1 || BLANK_CYCLES < 1) begin : g_bad_param
    $error("scan_sequencer: PRESCALE and BLANK_CYCLES must be >= 1");
  end
  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d, idx_nx;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          valid_q, tick_q, wrap_q, tick_d, dwell_end;
  assign idx_nx    = idx_q >= bus.i_LAST ? 3'd0 : idx_q + 3'd1;
  assign dwell_end = state_q == ACTIVE && dwell_q == DW'(PRESCALE - 1);
  assign dwell_d   = state_q == ACTIVE && !dwell_end ? dwell_q + DW'(1) : '0;
`ifdef SCAN_SEQ_BLANK_EN
  localparam logic [1:0] BLANK = 2'd2;
  localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  logic [BW-1:0] blank_q, blank_d;
  logic          blank_end;
  assign blank_end = state_q == BLANK && blank_q == BW'(BLANK_CYCLES - 1);
  assign blank_d   = state_q == BLANK && !blank_end ? blank_q + BW'(1) : '0;
  always_comb begin
    state_d = state_q == IDLE ? (bus.i_RUN || bus.i_STEP ? ACTIVE : IDLE) :
              dwell_end       ? BLANK :
              blank_end       ? (bus.i_RUN ? ACTIVE : IDLE) : state_q;
    idx_d   = blank_end ? idx_nx : idx_q;
  end
  always_ff @(posedge i_clk)
    blank_q <= i_rst ? '0 : blank_d;
`else
  always_comb begin
    state_d = state_q == IDLE ? (bus.i_RUN || bus.i_STEP ? ACTIVE : IDLE) :
              dwell_end       ? (bus.i_RUN ? ACTIVE : IDLE) : state_q;
    idx_d   = dwell_end ? idx_nx : idx_q;
  end
`endif
  // every entry into a dwell (from idle, blank or a back-to-back dwell) restarts the counter at 0
  assign tick_d = state_d == ACTIVE && dwell_d == '0;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      valid_q <= state_d == ACTIVE;
      tick_q  <= tick_d;
      wrap_q  <= tick_d && idx_d == 3'd0;
    end
  assign bus.i_A     = idx_q[2];
  assign bus.i_B     = idx_q[1];
  assign bus.i_C     = idx_q[0];
  assign bus.i_VALID = valid_q;
  assign bus.i_TICK  = tick_q;
  assign bus.i_WRAP  = wrap_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: randomized scoreboard bench comparing scan_sequencer against a period-position reference model
module tb_scan_sequencer;
  localparam int PRESCALE = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef SCAN_SEQ_BLANK_EN
  localparam int PER = PRESCALE + BLANK_CYCLES;
`else
  localparam int PER = PRESCALE;
`endif
  typedef struct packed {
    logic       valid;
    logic       tick;
    logic       wrap;
    logic [2:0] idx;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];
  scan_sequencer_if bus();
  scan_sequencer #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  bit   m_act = 1'b0;
  int   m_pos = 0;
  int   m_idx = 0;
  exp_t m_e;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 1'b0;
      m_pos = 0;
      m_idx = 0;
    end else if (!m_act) begin
      if (bus.i_RUN || bus.i_STEP) begin
        m_act = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == PER - 1) begin
      m_idx = m_idx >= int'(bus.i_LAST) ? 0 : m_idx + 1;
      m_pos = 0;
      m_act = bus.i_RUN;
    end else
      m_pos++;
    m_e.valid = m_act && m_pos < PRESCALE;
    m_e.tick  = m_act && m_pos == 0;
    m_e.wrap  = m_e.tick && m_idx == 0;
    m_e.idx   = 3'(m_idx);
    sb.push_back(m_e);
  end
  exp_t got, want;
  always @(negedge clk) begin
    got = {bus.i_VALID, bus.i_TICK, bus.i_WRAP, bus.i_A, bus.i_B, bus.i_C};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc %0d got %b", cyc, got);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL outputs cyc %0d got v%b t%b w%b idx%0d want v%b t%b w%b idx%0d",
                 cyc, got.valid, got.tick, got.wrap, got.idx, want.valid, want.tick, want.wrap, want.idx);
      end
    end
  end
  task automatic wait_tick(input string name);
    int k;
    for (k = 0; k < 100 && bus.i_TICK !== 1'b1; k++) @(negedge clk);
    if (k == 100) begin
      checks++;
      errors++;
      $display("FAIL %s no i_TICK within 100 cycles got 0 want 1", name);
    end
  endtask
  initial begin
    bus.i_RUN = 1'b1;
    bus.i_STEP = 1'b0;
    bus.i_LAST = 3'd7;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (PER * 9 + 3) @(negedge clk);
    bus.i_LAST = 3'd2;
    repeat (PER * 8) @(negedge clk);
    for (int k = 0; k < 100 && !(bus.i_TICK === 1'b1 && {bus.i_A, bus.i_B, bus.i_C} == 3'd2); k++) @(negedge clk);
    bus.i_LAST = 3'd0;
    repeat (PER * 4) @(negedge clk);
    bus.i_LAST = 3'd7;
    bus.i_RUN = 1'b0;
    repeat (PER * 2 + 2) @(negedge clk);
    bus.i_STEP = 1'b1;
    @(negedge clk);
    bus.i_STEP = 1'b0;
    @(negedge clk);
    bus.i_STEP = 1'b1;
    @(negedge clk);
    bus.i_STEP = 1'b0;
    repeat (PER * 2) @(negedge clk);
    bus.i_RUN = 1'b1;
    wait_tick("mid_run_drop");
    bus.i_RUN = 1'b0;
    repeat (PER * 2) @(negedge clk);
    bus.i_RUN = 1'b1;
    wait_tick("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (PER * 3) @(negedge clk);
    repeat (4000) begin
      bus.i_RUN  = $urandom_range(0, 3) != 0;
      bus.i_STEP = $urandom_range(0, 5) == 0;
      bus.i_LAST = 3'($urandom_range(0, 7));
      rst        = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    bus.i_RUN = 1'b0;
    bus.i_STEP = 1'b0;
    rst = 1'b0;
    repeat (PER + 4) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream stage of the 3-to-8 decoder.
- Generates the 3-bit select {i_A, i_B, i_C} (i_A = MSB, i_C = LSB) as a timed scan index, plus a valid qualifier.
- Each index is held for a programmable dwell period, followed by a blanking gap, wrapping at a runtime-selectable last index.
- Used for multiplexed display/matrix scanning, with the decoder's one-hot output qualified by i_VALID.

Parameters:
- PRESCALE, 1000, dwell length in clocks per index (≥1).
- BLANK_CYCLES, 4, clocks of blanking between indices (≥1).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_RUN  input  1  continuous scan enable (level).
- i_STEP  input  1  single-dwell request (pulse); honoured only in IDLE.
- i_LAST  input  3  highest index before wrap to 0.
- i_A  output  1  select bit 2 (MSB) to decoder.
- i_B  output  1  select bit 1 to decoder.
- i_C  output  1  select bit 0 (LSB) to decoder.
- i_VALID  output  1  high while the select is in its dwell; decoder output is meaningful only then.
- i_TICK  output  1  one-cycle pulse in the first dwell cycle of each index.
- i_WRAP  output  1  equals i_TICK AND index==0.

Behaviour:
- One clock, i_clk; i_rst is synchronous and active-high. All outputs are registered.
- Reset values: idx=0 (i_A=i_B=i_C=0), state=IDLE, i_VALID=0, i_TICK=0, i_WRAP=0, dwell and blank counters 0. Reset asserted mid-operation forces these values at the next edge.
- States:
  - IDLE: i_VALID=0; idx held. If i_RUN=1 or i_STEP=1, go to ACTIVE at the next edge. Both high is identical to i_RUN alone.
  - ACTIVE: i_VALID=1 for exactly PRESCALE cycles. i_TICK=1 in the first cycle only. The dwell counter counts 0..PRESCALE-1; at PRESCALE-1, go to BLANK.
  - BLANK: i_VALID=0 for exactly BLANK_CYCLES cycles. On the last cycle, idx advances. Next state is ACTIVE if i_RUN=1 at that cycle, else IDLE.
- Advance rule: if idx ≥ i_LAST then idx←0, else idx←idx+1. i_LAST is sampled only at the advance cycle. Lowering i_LAST below the current idx wraps on the next advance.
- i_LAST=0: idx stays 0; i_WRAP accompanies every i_TICK.
- Select timing: idx changes only while i_VALID=0, so {i_A,i_B,i_C} is stable throughout every dwell.
- i_STEP outside IDLE is ignored and not queued.
- Deasserting i_RUN mid-dwell: the dwell completes, then BLANK runs, idx advances, then IDLE.
- Running period per index: PRESCALE+BLANK_CYCLES clocks, with i_TICK spaced exactly that far apart.
- Entering ACTIVE from IDLE presents the current idx without advancing it.
- Dwell counter width: $clog2(PRESCALE), minimum 1 bit.

Optional Feature:
- Macro: SCAN_SEQ_BLANK_EN.
- Defined: BLANK state present, as above.
- Undefined: no BLANK state and BLANK_CYCLES is ignored.
  - At dwell end, idx advances in the same cycle.
  - If i_RUN=1, the next cycle is ACTIVE with i_TICK, and i_VALID stays continuously high while running.
  - If i_RUN=0, state goes to IDLE with idx advanced.
  - The running period is PRESCALE clocks.

Test Plan:
- Reset: hold i_rst 2 cycles with i_RUN=1 → i_A/i_B/i_C=0, i_VALID=0, i_TICK=0, i_WRAP=0; no activity until i_rst falls.
- Continuous scan, PRESCALE=4, BLANK_CYCLES=2, i_LAST=7, i_RUN=1 → i_TICK every 6 clocks; idx sequence 0,1,…,7,0; i_VALID high 4 / low 2; i_WRAP only on the idx=0 ticks.
- Wrap control: i_LAST=2 → idx 0,1,2,0. Set i_LAST=0 while idx=2 → next idx 0, then 0 repeated with i_WRAP on every tick.
- Single step: i_RUN=0, idx=3, one-cycle i_STEP → i_TICK with idx=3, i_VALID 4 cycles, BLANK 2, IDLE with idx=4. A second i_STEP during ACTIVE has no effect.
- Mid-operation: drop i_RUN in dwell cycle 1 → dwell finishes, blank, idx+1, IDLE. Assert i_rst in dwell cycle 2 → all outputs at reset values on the next edge.
- SCAN_SEQ_BLANK_EN undefined, PRESCALE=4, i_RUN=1 → i_VALID constant 1, i_TICK every 4 clocks, select changes on the tick cycles.
